frame_prbs_ctrl: RTL and testbench
==================================

# frame_prbs_ctrl

Sequencing controller for the frame generator's PRBS payload source. It walks a frame-level state machine (START → DATA×N → TERM → IDLE gap×M) one slot per valid cycle. It drives step and reseed strobes to the PRBS generator, aligned so each DATA slot uses exactly one fresh PRBS word. It sits between the frame-generator configuration registers and the PRBS generator / block encoder.

## Interface
- `LEN_BITS`, 16: width of payload-length and frame-count fields.
- `GAP_BITS`, 8: width of inter-frame gap field.
- `i_clock`  in  1  sole clock.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  run request; level-sensitive.
- `i_valid`  in  1  slot strobe; the controller advances only on cycles with `i_valid`=1.
- `i_data_len`  in  LEN_BITS  DATA slots per frame; sampled in START.
- `i_gap_len`  in  GAP_BITS  IDLE slots after TERM; sampled in START.
- `i_n_frames`  in  LEN_BITS  frames to send; 0 = continuous.
- `i_reseed`  in  1  1 = reload PRBS seed at every START.
- `o_slot_valid`  out  1  registered; a slot is presented this cycle.
- `o_block_type`  out  2  registered; IDLE=0, START=1, DATA=2, TERM=3.
- `o_prbs_step`  out  1  registered; drives PRBS `i_enable` (PRBS `i_valid` tied high).
- `o_prbs_load`  out  1  registered; drives PRBS `i_reset` (synchronous reseed).
- `o_frame_count`  out  LEN_BITS  frames completed since leaving IDLE_ST; wraps modulo 2^LEN_BITS.
- `o_busy`  out  1  state ≠ IDLE_ST and ≠ DONE_ST.
- `o_done`  out  1  `i_n_frames` frames completed.

## Operation
- States: IDLE_ST, START_ST, DATA_ST, TERM_ST, GAP_ST, DONE_ST.
- The state and all counters change only on cycles with `i_valid`=1. With `i_valid`=0 everything holds and the strobes (`o_slot_valid`, `o_prbs_step`, `o_prbs_load`) are 0.
- IDLE_ST: no slots are emitted. Transition to START_ST on `i_enable`=1. `o_frame_count` clears on leaving IDLE_ST.
- START_ST: emits one START slot.
  - Latches `i_data_len`, `i_gap_len` and `i_n_frames`.
  - `o_prbs_load`=`i_reseed`.
  - Next state is DATA_ST if the latched length is >0, else TERM_ST.
- DATA_ST: emits one DATA slot per valid cycle with `o_prbs_step`=1. A down-counter is loaded with the length and moves to TERM_ST after the last DATA slot.
- TERM_ST: emits one TERM slot and increments `o_frame_count`. Next state, by priority:
  - 1) DONE_ST if `i_n_frames`≠0 and count+1 = `i_n_frames`;
  - 2) GAP_ST if gap >0;
  - 3) START_ST if `i_enable`;
  - 4) IDLE_ST otherwise.
- GAP_ST: emits `i_gap_len` IDLE slots. After the last one, go to START_ST if `i_enable`, else IDLE_ST.
- DONE_ST: no slots are emitted and `o_done`=1. Return to IDLE_ST when `i_enable`=0.
- Deasserting `i_enable` mid-frame never truncates the frame: START, all DATA slots and TERM complete, then the gap, then IDLE_ST.
- Configuration changes mid-frame are ignored until the next START_ST.
- The DATA and GAP phases share one LEN_BITS down-counter; the gap value is zero-extended.

## Timing
- Reset values: state IDLE_ST; every output 0; counters 0.
- The registered outputs describe the slot presented in the current cycle.
  - `o_prbs_step`=1 coincides with `o_block_type`=DATA. The encoder samples the PRBS output in that cycle and the generator advances at the closing edge, giving zero extra latency.
  - `o_prbs_load`=1 coincides with the START slot, so the first DATA slot carries SEED.
- Frame length in slots is `i_data_len`+2. The gap is exactly `i_gap_len` slots. Back-to-back frames with gap 0 have no IDLE slot between TERM and START.
- First START slot: `o_slot_valid` rises on the first valid cycle after `i_enable` is seen in IDLE_ST (one valid cycle of latency).
- `o_done` rises in the cycle after the final TERM slot.
- Asynchronous reset mid-frame: immediate return to the reset values. No TERM is emitted and the PRBS is not reloaded by this block.

## Structure
- Shared package `pcs_frame_pkg`:
  - block-type codes IDLE/START/DATA/TERM;
  - the state enumeration;
  - default LEN_BITS and GAP_BITS.
- One sub-module, `slot_down_counter`: loadable, valid-gated down-counter with a `last` flag, instantiated once.
- The state register, frame counter and output registers live in the top module.

## Test plan
- `i_data_len`=4, `i_gap_len`=2, `i_n_frames`=2, `i_valid`=1 constant → type sequence S,D,D,D,D,T,I,I,S,D,D,D,D,T; `o_done`=1 next cycle; `o_frame_count`=2; 8 step pulses total.
- Same configuration with `i_valid` toggling 1,0,1,0 → identical slot sequence on valid cycles only; strobes 0 on every invalid cycle.
- `i_data_len`=0, `i_gap_len`=0, `i_n_frames`=0 → continuous S,T,S,T…; `o_prbs_step` never 1.
- `i_reseed`=1, `i_data_len`=3 → `o_prbs_load` pulses on each START; the PRBS word on the first DATA slot equals SEED every frame.
- `i_enable` dropped during the 2nd DATA slot of a 5-slot payload → remaining 3 DATA slots, TERM, the gap, then IDLE_ST; `o_busy`→0.
- `i_reset` asserted mid-DATA → `o_slot_valid`, `o_block_type`, `o_busy` and `o_frame_count` go to 0 asynchronously; restart gives a clean START.

Source files
------------

// File: rtl/pcs_frame_pkg.sv
// Shared definitions for the frame generator: block-type codes, the frame
// sequencing states and default field widths.
package pcs_frame_pkg;

    localparam int DEF_LEN_BITS = 16;
    localparam int DEF_GAP_BITS = 8;

    typedef enum logic [1:0] {
        BT_IDLE  = 2'd0,
        BT_START = 2'd1,
        BT_DATA  = 2'd2,
        BT_TERM  = 2'd3
    } block_type_e;

    typedef enum logic [2:0] {
        IDLE_ST,
        START_ST,
        DATA_ST,
        TERM_ST,
        GAP_ST,
        DONE_ST
    } frame_state_e;

    // Block type carried by the slot a state presents (IDLE when no slot).
    function automatic block_type_e block_of(input frame_state_e s);
        case (s)
            START_ST: return BT_START;
            DATA_ST:  return BT_DATA;
            TERM_ST:  return BT_TERM;
            default:  return BT_IDLE;
        endcase
    endfunction

    function automatic logic emits_slot(input frame_state_e s);
        return (s == START_ST) || (s == DATA_ST) || (s == TERM_ST) || (s == GAP_ST);
    endfunction

endpackage

// File: rtl/slot_down_counter.sv
// Loadable down-counter that only moves on valid cycles; last flags the final
// slot of the phase currently being counted.
module slot_down_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] load_value,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (valid) begin
            if (load) begin
                count <= load_value;
            end else if (step && (count != '0)) begin
                count <= count - W'(1);
            end
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/frame_prbs_ctrl.sv
// Frame-level sequencer for the PRBS payload source: START, DATA x N, TERM,
// IDLE gap x M, advancing one slot per valid cycle.
module frame_prbs_ctrl
    import pcs_frame_pkg::*;
#(
    parameter int LEN_BITS = DEF_LEN_BITS,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [LEN_BITS-1:0] i_data_len,
    input  logic [GAP_BITS-1:0] i_gap_len,
    input  logic [LEN_BITS-1:0] i_n_frames,
    input  logic                i_reseed,
    output logic                o_slot_valid,
    output logic [1:0]          o_block_type,
    output logic                o_prbs_step,
    output logic                o_prbs_load,
    output logic [LEN_BITS-1:0] o_frame_count,
    output logic                o_busy,
    output logic                o_done
);

    frame_state_e        state, next_state;
    logic [GAP_BITS-1:0] gap_q;
    logic [LEN_BITS-1:0] n_frames_q;
    logic [LEN_BITS-1:0] frame_count_q;
    logic [LEN_BITS-1:0] count_inc;

    logic                cnt_load;
    logic                cnt_step;
    logic [LEN_BITS-1:0] cnt_load_value;
    logic                cnt_last;

    block_type_e         block_q;
    logic                slot_q;
    logic                step_q;
    logic                load_q;
    logic                busy_q;
    logic                done_q;

    assign count_inc = frame_count_q + LEN_BITS'(1);

    slot_down_counter #(
        .W(LEN_BITS)
    ) u_slot_cnt (
        .clock      (i_clock),
        .reset      (i_reset),
        .valid      (i_valid),
        .load       (cnt_load),
        .step       (cnt_step),
        .load_value (cnt_load_value),
        .last       (cnt_last)
    );

    always_comb begin
        next_state     = state;
        cnt_load       = 1'b0;
        cnt_step       = 1'b0;
        cnt_load_value = '0;
        unique case (state)
            IDLE_ST: begin
                if (i_enable) next_state = START_ST;
            end
            START_ST: begin
                cnt_load       = 1'b1;
                cnt_load_value = i_data_len;
                next_state     = (i_data_len != '0) ? DATA_ST : TERM_ST;
            end
            DATA_ST: begin
                cnt_step = 1'b1;
                if (cnt_last) next_state = TERM_ST;
            end
            TERM_ST: begin
                // The shared counter is reloaded with the gap here for GAP_ST.
                cnt_load       = 1'b1;
                cnt_load_value = LEN_BITS'(gap_q);
                if ((n_frames_q != '0) && (count_inc == n_frames_q)) next_state = DONE_ST;
                else if (gap_q != '0)                                next_state = GAP_ST;
                else if (i_enable)                                   next_state = START_ST;
                else                                                 next_state = IDLE_ST;
            end
            GAP_ST: begin
                cnt_step = 1'b1;
                if (cnt_last) next_state = i_enable ? START_ST : IDLE_ST;
            end
            DONE_ST: begin
                if (!i_enable) next_state = IDLE_ST;
            end
            default: next_state = IDLE_ST;
        endcase
    end

    // Output registers describe the slot of the state being entered, so they
    // line up with the state register on the following cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE_ST;
            gap_q         <= '0;
            n_frames_q    <= '0;
            frame_count_q <= '0;
            block_q       <= BT_IDLE;
            slot_q        <= 1'b0;
            step_q        <= 1'b0;
            load_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (i_valid) begin
            state <= next_state;
            if (state == START_ST) begin
                gap_q      <= i_gap_len;
                n_frames_q <= i_n_frames;
            end
            if ((state == IDLE_ST) && i_enable) frame_count_q <= '0;
            else if (state == TERM_ST)          frame_count_q <= count_inc;
            block_q <= block_of(next_state);
            slot_q  <= emits_slot(next_state);
            step_q  <= (next_state == DATA_ST);
            load_q  <= (next_state == START_ST) && i_reseed;
            busy_q  <= (next_state != IDLE_ST) && (next_state != DONE_ST);
            done_q  <= (next_state == DONE_ST);
        end
    end

    // Strobes are qualified by the slot strobe so the PRBS generator and the
    // encoder never see a step, load or slot on an invalid cycle.
    assign o_slot_valid  = slot_q & i_valid;
    assign o_prbs_step   = step_q & i_valid;
    assign o_prbs_load   = load_q & i_valid;
    assign o_block_type  = block_q;
    assign o_frame_count = frame_count_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_frame_prbs_ctrl.sv
// Directed bench for frame_prbs_ctrl: expected slot types are queued as each
// scenario is set up and popped as the controller presents slots.
module tb_frame_prbs_ctrl;

    localparam int          LEN_BITS = 16;
    localparam int          GAP_BITS = 8;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [1:0]  T_IDLE   = 2'd0;
    localparam logic [1:0]  T_START  = 2'd1;
    localparam logic [1:0]  T_DATA   = 2'd2;
    localparam logic [1:0]  T_TERM   = 2'd3;

    logic                clk = 1'b0;
    logic                i_reset;
    logic                i_enable;
    logic                i_valid;
    logic [LEN_BITS-1:0] i_data_len;
    logic [GAP_BITS-1:0] i_gap_len;
    logic [LEN_BITS-1:0] i_n_frames;
    logic                i_reseed;
    logic                o_slot_valid;
    logic [1:0]          o_block_type;
    logic                o_prbs_step;
    logic                o_prbs_load;
    logic [LEN_BITS-1:0] o_frame_count;
    logic                o_busy;
    logic                o_done;

    int checks = 0;
    int errors = 0;
    int steps  = 0;
    int loads  = 0;
    logic       first_data     = 1'b0;
    logic       last_slot_term = 1'b0;
    logic [1:0] exp_q[$];
    logic [15:0] prbs_word = 16'h0001;

    frame_prbs_ctrl #(
        .LEN_BITS(LEN_BITS),
        .GAP_BITS(GAP_BITS)
    ) dut (
        .i_clock      (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_valid      (i_valid),
        .i_data_len   (i_data_len),
        .i_gap_len    (i_gap_len),
        .i_n_frames   (i_n_frames),
        .i_reseed     (i_reseed),
        .o_slot_valid (o_slot_valid),
        .o_block_type (o_block_type),
        .o_prbs_step  (o_prbs_step),
        .o_prbs_load  (o_prbs_load),
        .o_frame_count(o_frame_count),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    // Reference PRBS generator driven by the controller's strobes.
    always @(posedge clk) begin
        if (o_prbs_load)      prbs_word <= SEED;
        else if (o_prbs_step) prbs_word <= {prbs_word[14:0], prbs_word[15] ^ prbs_word[13] ^ prbs_word[12] ^ prbs_word[10]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int len);
        exp_q.push_back(T_START);
        repeat (len) exp_q.push_back(T_DATA);
        exp_q.push_back(T_TERM);
    endtask

    task automatic push_gap(input int len);
        repeat (len) exp_q.push_back(T_IDLE);
    endtask

    // One clock: drive the slot strobe, sample at the falling edge, score.
    task automatic do_cycle(input logic v);
        logic [1:0] e;
        i_valid = v;
        @(negedge clk);
        if (!v) chk("invalid_strobes", 32'({o_slot_valid, o_prbs_step, o_prbs_load}), 0);
        if (o_slot_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL extra_slot observed=%0d expected=no_slot", o_block_type);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("slot_type", 32'(o_block_type), 32'(e));
                chk("step_align", 32'(o_prbs_step), 32'(e == T_DATA));
                chk("load_align", 32'(o_prbs_load), 32'((e == T_START) && i_reseed));
                if (e == T_START) first_data = 1'b1;
                if ((e == T_DATA) && first_data) begin
                    if (i_reseed) chk("seed_word", 32'(prbs_word), 32'(SEED));
                    first_data = 1'b0;
                end
            end
        end else begin
            chk("no_slot_strobes", 32'({o_prbs_step, o_prbs_load}), 0);
        end
        steps += int'(o_prbs_step);
        loads += int'(o_prbs_load);
        last_slot_term = o_slot_valid && (o_block_type == T_TERM);
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int len, input int gap, input int nf, input logic rs);
        i_data_len = LEN_BITS'(len);
        i_gap_len  = GAP_BITS'(gap);
        i_n_frames = LEN_BITS'(nf);
        i_reseed   = rs;
        steps      = 0;
        loads      = 0;
    endtask

    task automatic wait_done(input int budget, input logic toggle);
        int c;
        c = 0;
        while ((c < budget) && !o_done) begin
            do_cycle(toggle ? ~c[0] : 1'b1);
            c++;
        end
        chk("done_seen", 32'(o_done), 1);
        chk("done_after_term", 32'(last_slot_term), 1);
    endtask

    task automatic leave_done();
        i_enable = 1'b0;
        do_cycle(1'b1);
        chk("idle_after_done", 32'({o_busy, o_done}), 0);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_valid  = 1'b0;
        configure(0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_slot_valid", 32'(o_slot_valid), 0);
        chk("reset_block_type", 32'(o_block_type), 0);
        chk("reset_step_load", 32'({o_prbs_step, o_prbs_load}), 0);
        chk("reset_busy_done", 32'({o_busy, o_done}), 0);
        chk("reset_frame_count", 32'(o_frame_count), 0);
        @(negedge clk);
        i_reset = 1'b0;
        @(posedge clk);
        #1;

        // Two frames, len 4, gap 2, continuous valid.
        configure(4, 2, 2, 1'b0);
        push_frame(4); push_gap(2); push_frame(4);
        i_enable = 1'b1;
        wait_done(60, 1'b0);
        chk("s1_frame_count", 32'(o_frame_count), 2);
        chk("s1_steps", 32'(steps), 8);
        chk("s1_queue_empty", 32'(exp_q.size()), 0);
        chk("s1_busy", 32'(o_busy), 0);
        leave_done();

        // Same frames with the slot strobe toggling every cycle.
        configure(4, 2, 2, 1'b0);
        push_frame(4); push_gap(2); push_frame(4);
        i_enable = 1'b1;
        wait_done(120, 1'b1);
        chk("s2_frame_count", 32'(o_frame_count), 2);
        chk("s2_steps", 32'(steps), 8);
        chk("s2_queue_empty", 32'(exp_q.size()), 0);
        leave_done();

        // Empty payload, no gap, continuous: S,T,S,T...
        configure(0, 0, 0, 1'b0);
        repeat (6) push_frame(0);
        i_enable = 1'b1;
        for (int c = 0; c < 12; c++) do_cycle(1'b1);
        i_enable = 1'b0;
        do_cycle(1'b1);
        chk("s3_steps", 32'(steps), 0);
        chk("s3_frame_count", 32'(o_frame_count), 6);
        chk("s3_queue_empty", 32'(exp_q.size()), 0);
        chk("s3_busy", 32'(o_busy), 0);

        // Reseed on every START; first DATA word must be the seed each frame.
        configure(3, 1, 3, 1'b1);
        push_frame(3); push_gap(1); push_frame(3); push_gap(1); push_frame(3);
        i_enable = 1'b1;
        wait_done(80, 1'b0);
        chk("s4_loads", 32'(loads), 3);
        chk("s4_steps", 32'(steps), 9);
        chk("s4_frame_count", 32'(o_frame_count), 3);
        chk("s4_queue_empty", 32'(exp_q.size()), 0);
        leave_done();

        // Enable dropped during the 2nd DATA slot: frame and gap still finish.
        configure(5, 2, 0, 1'b0);
        push_frame(5); push_gap(2);
        i_enable = 1'b1;
        for (int c = 0; c < 3; c++) do_cycle(1'b1);
        i_enable = 1'b0;
        for (int c = 0; (c < 30) && o_busy; c++) do_cycle(1'b1);
        chk("s5_busy", 32'(o_busy), 0);
        chk("s5_queue_empty", 32'(exp_q.size()), 0);
        chk("s5_steps", 32'(steps), 5);
        repeat (3) do_cycle(1'b1);
        chk("s5_frame_count", 32'(o_frame_count), 1);
        chk("s5_block_type", 32'(o_block_type), 0);

        // Asynchronous reset in the middle of the second frame's payload.
        configure(4, 0, 0, 1'b0);
        push_frame(4); exp_q.push_back(T_START); exp_q.push_back(T_DATA); exp_q.push_back(T_DATA);
        i_enable = 1'b1;
        for (int c = 0; c < 10; c++) do_cycle(1'b1);
        chk("s6_pre_count", 32'(o_frame_count), 1);
        chk("s6_pre_busy", 32'(o_busy), 1);
        #1;
        i_reset = 1'b1;
        #1;
        chk("s6_rst_slot_valid", 32'(o_slot_valid), 0);
        chk("s6_rst_block_type", 32'(o_block_type), 0);
        chk("s6_rst_busy", 32'(o_busy), 0);
        chk("s6_rst_frame_count", 32'(o_frame_count), 0);
        chk("s6_queue_empty", 32'(exp_q.size()), 0);
        @(negedge clk);
        i_reset = 1'b0;
        i_n_frames = LEN_BITS'(1);
        push_frame(4);
        @(posedge clk);
        #1;
        wait_done(30, 1'b0);
        chk("s6_restart_count", 32'(o_frame_count), 1);
        chk("s6_restart_queue", 32'(exp_q.size()), 0);
        leave_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
